riscv_axil_master: RTL and testbench
====================================

RISCV_AXIL_MASTER -- requirements
Module: riscv_axil_master

Interface
REQ-001 TIMEOUT_CYCLES, default 1024: max cycles per outstanding transaction before forced error; 0 disables the timeout.
REQ-002 clk  input  1  single clock for all logic.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  CPU load/store request valid.
REQ-005 req_ready  output  1  block idle and accepting a request.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_wdata  input  32  store data.
REQ-009 req_wstrb  input  4  store byte strobes.
REQ-010 rsp_valid  output  1  one-cycle completion pulse.
REQ-011 rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-012 rsp_err  output  1  SLVERR/DECERR or timeout.
REQ-013 M_AXI_AWADDR / M_AXI_AWVALID  output  32 / 1  write address channel.
REQ-014 M_AXI_AWREADY  input  1  write address accepted.
REQ-015 M_AXI_WDATA / M_AXI_WSTRB / M_AXI_WVALID  output  32 / 4 / 1  write data channel.
REQ-016 M_AXI_WREADY  input  1  write data accepted.
REQ-017 M_AXI_BRESP / M_AXI_BVALID  input  2 / 1  write response.
REQ-018 M_AXI_BREADY  output  1  write response accept.
REQ-019 M_AXI_ARADDR / M_AXI_ARVALID  output  32 / 1  read address channel.
REQ-020 M_AXI_ARREADY  input  1  read address accepted.
REQ-021 M_AXI_RDATA / M_AXI_RRESP / M_AXI_RVALID  input  32 / 2 / 1  read data channel.
REQ-022 M_AXI_RREADY  output  1  read data accept.

Function
REQ-023 FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP; one transaction outstanding at most.
REQ-024 req_ready = 1 only in IDLE; request captured on req_valid & req_ready at edge T; req_valid ignored in all other states.
REQ-025 Issued address = {req_addr[31:2],2'b00}; captured addr/wdata/wstrb held stable on the AXI buses while the matching VALID is high.
REQ-026 Store: AWVALID and WVALID both rise at T+1; each drops the cycle after its own handshake; AW/W handshakes in the same cycle or in either order are both legal.
REQ-027 Enter WR_RESP once both AW and W handshakes are done; BREADY = 1 only in WR_RESP; BVALID before then is not accepted.
REQ-028 Load: ARVALID rises at T+1 and holds until ARREADY; then RD_DATA with RREADY = 1 until RVALID.
REQ-029 On B or R handshake, capture response and go to RESP; rsp_valid = 1 for exactly the next cycle; then IDLE.
REQ-030 rsp_err = BRESP[1] or RRESP[1]; OKAY and EXOKAY give rsp_err = 0; rsp_rdata = RDATA only for an error-free load, else 0.
REQ-031 Latency with zero-wait slave: request at T, AXI handshake at T+1, B/R at T+2, rsp_valid at T+3, req_ready at T+4.
REQ-032 A store with wstrb = 0000 is still issued on AXI unchanged.
REQ-033 Timeout counter clears on accept and increments every cycle outside IDLE/RESP.
REQ-034 If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES, all M_AXI VALID/READY drop next cycle and the FSM enters RESP with rsp_err = 1 and rsp_rdata = 0.
REQ-035 The counter saturates and does not wrap.
REQ-036 rsp_valid/rsp_err/rsp_rdata are registered outputs; M_AXI VALID/READY have no combinational path from AXI inputs.

Reset
REQ-037 With rst high at an edge: FSM to IDLE, all M_AXI VALID/READY = 0, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, counter = 0, req_ready = 1 the following cycle.
REQ-038 Reset mid-transaction aborts it with no rsp_valid pulse; captured request registers clear to 0.

Verification
REQ-039 Store addr 0x4000_0006, data 0xDEADBEEF, strb 1111, zero-wait slave -> AWADDR 0x4000_0004 at T+1, BREADY at T+2, rsp_valid at T+3 with rsp_err 0.
REQ-040 Store with WREADY delayed 3 cycles after AWREADY, early BVALID -> AWVALID drops after 1 cycle, WVALID held 4 cycles, B accepted only after W handshake, single rsp_valid.
REQ-041 Load 0x4000_0010, RDATA 0x1234_5678, RRESP 00 -> rsp_rdata 0x1234_5678, rsp_err 0; repeat with RRESP 10 -> rsp_rdata 0, rsp_err 1.
REQ-042 TIMEOUT_CYCLES = 8, slave never asserts ARREADY -> ARVALID drops after 8 cycles, rsp_valid with rsp_err 1, req_ready back next cycle.
REQ-043 rst asserted while in RD_DATA -> next cycle RREADY 0, no rsp_valid, req_ready 1; new load then completes normally.
REQ-044 req_valid held high across two back-to-back requests -> second accepted only once req_ready returns, exactly two rsp_valid pulses.

Source files
------------

// File: rtl/riscv_axil_master.sv
// CPU load/store to AXI4-Lite master bridge, one transaction outstanding.
// Latency: request accepted at T, rsp_valid at T+3 with a zero-wait slave; req_ready only while idle.
module riscv_axil_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] M_AXI_AWADDR,
    output logic        M_AXI_AWVALID,
    input  logic        M_AXI_AWREADY,
    output logic [31:0] M_AXI_WDATA,
    output logic [3:0]  M_AXI_WSTRB,
    output logic        M_AXI_WVALID,
    input  logic        M_AXI_WREADY,
    input  logic [1:0]  M_AXI_BRESP,
    input  logic        M_AXI_BVALID,
    output logic        M_AXI_BREADY,
    output logic [31:0] M_AXI_ARADDR,
    output logic        M_AXI_ARVALID,
    input  logic        M_AXI_ARREADY,
    input  logic [31:0] M_AXI_RDATA,
    input  logic [1:0]  M_AXI_RRESP,
    input  logic        M_AXI_RVALID,
    output logic        M_AXI_RREADY
);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic [31:0] cnt_q, cnt_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        busy;
    logic        timeout_hit;
    logic        fire_timeout;
    logic        unused_resp_lsb;

    // Only the error bit of the response codes matters; OKAY and EXOKAY are both success.
    assign unused_resp_lsb = M_AXI_BRESP[0] ^ M_AXI_RRESP[0];

    assign busy        = (state_q != IDLE) && (state_q != RESP);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q >= TIMEOUT_CYCLES - 1);

    // All handshake outputs decode registered state, so none follows an AXI input combinationally.
    assign req_ready     = (state_q == IDLE);
    assign M_AXI_AWVALID = (state_q == WR_ADDR_DATA) && !aw_done_q;
    assign M_AXI_WVALID  = (state_q == WR_ADDR_DATA) && !w_done_q;
    assign M_AXI_BREADY  = (state_q == WR_RESP);
    assign M_AXI_ARVALID = (state_q == RD_ADDR);
    assign M_AXI_RREADY  = (state_q == RD_DATA);
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_err       = rsp_err_q;
    assign rsp_rdata     = rsp_rdata_q;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        cnt_d        = cnt_q;
        rsp_valid_d  = 1'b0;
        rsp_err_d    = rsp_err_q;
        rsp_rdata_d  = rsp_rdata_q;
        fire_timeout = 1'b0;

        if (busy && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d    = {req_addr[31:2], 2'b00};
                    wdata_d   = req_wdata;
                    wstrb_d   = req_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    cnt_d     = 32'd0;
                    state_d   = req_we ? WR_ADDR_DATA : RD_ADDR;
                end
            end
            WR_ADDR_DATA: begin
                aw_done_d = aw_done_q | M_AXI_AWREADY;
                w_done_d  = w_done_q | M_AXI_WREADY;
                if (aw_done_d && w_done_d) begin
                    state_d = WR_RESP;
                end else begin
                    fire_timeout = timeout_hit;
                end
            end
            WR_RESP: begin
                if (M_AXI_BVALID) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = M_AXI_BRESP[1];
                    rsp_rdata_d = 32'd0;
                end else begin
                    fire_timeout = timeout_hit;
                end
            end
            RD_ADDR: begin
                if (M_AXI_ARREADY) begin
                    state_d = RD_DATA;
                end else begin
                    fire_timeout = timeout_hit;
                end
            end
            RD_DATA: begin
                if (M_AXI_RVALID) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = M_AXI_RRESP[1];
                    rsp_rdata_d = M_AXI_RRESP[1] ? 32'd0 : M_AXI_RDATA;
                end else begin
                    fire_timeout = timeout_hit;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (fire_timeout) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            wstrb_q     <= 4'd0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            cnt_q       <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

endmodule

// File: tb/tb_riscv_axil_master.sv
// Directed bench for riscv_axil_master: stores, loads, error responses, timeout, reset abort, back-to-back.
module tb_riscv_axil_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    int n_cmp = 0;
    int n_mis = 0;

    riscv_axil_master #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic slave_idle();
        awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
        arready = 0; rvalid = 0; rresp = 2'b00; rdata = 32'd0;
    endtask

    // Present one request for a single accept edge; returns at the T+1 sample point.
    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        req_valid = 1; req_we = we; req_addr = a; req_wdata = d; req_wstrb = s;
        step();
        req_valid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int accepts;
        int pulses;
        int second_idx;

        rst = 1; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
        slave_idle();
        step(); step();
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_awvalid", 32'(awvalid), 32'd0);
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        rst = 0;
        step();
        chk("idle_rsp_err", 32'(rsp_err), 32'd0);
        chk("idle_rsp_rdata", rsp_rdata, 32'd0);
        chk("idle_bready", 32'(bready), 32'd0);

        // Zero-wait store, unaligned address is word-aligned on the bus
        awready = 1; wready = 1; bvalid = 1; bresp = 2'b00;
        issue(1, 32'h4000_0006, 32'hDEAD_BEEF, 4'hF);
        chk("st1_awvalid", 32'(awvalid), 32'd1);
        chk("st1_wvalid", 32'(wvalid), 32'd1);
        chk("st1_awaddr", awaddr, 32'h4000_0004);
        chk("st1_wdata", wdata, 32'hDEAD_BEEF);
        chk("st1_wstrb", 32'(wstrb), 32'hF);
        chk("st1_req_ready", 32'(req_ready), 32'd0);
        step();
        chk("st1_aw_drop", 32'(awvalid), 32'd0);
        chk("st1_bready", 32'(bready), 32'd1);
        step();
        chk("st1_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("st1_rsp_err", 32'(rsp_err), 32'd0);
        chk("st1_rsp_rdata", rsp_rdata, 32'd0);
        step();
        chk("st1_rsp_drop", 32'(rsp_valid), 32'd0);
        chk("st1_req_ready", 32'(req_ready), 32'd1);
        slave_idle();

        // Store with W delayed three cycles after AW, early BVALID, zero strobes, EXOKAY
        awready = 1; wready = 0; bvalid = 1; bresp = 2'b01;
        issue(1, 32'h4000_0020, 32'hA5A5_A5A5, 4'h0);
        chk("st2_wstrb0", 32'(wstrb), 32'h0);
        chk("st2_awvalid", 32'(awvalid), 32'd1);
        chk("st2_wvalid_c1", 32'(wvalid), 32'd1);
        step();
        awready = 0;
        chk("st2_aw_drop", 32'(awvalid), 32'd0);
        chk("st2_wvalid_c2", 32'(wvalid), 32'd1);
        chk("st2_no_bready_c2", 32'(bready), 32'd0);
        step();
        chk("st2_wvalid_c3", 32'(wvalid), 32'd1);
        chk("st2_no_bready_c3", 32'(bready), 32'd0);
        step();
        chk("st2_wvalid_c4", 32'(wvalid), 32'd1);
        chk("st2_no_bready_c4", 32'(bready), 32'd0);
        chk("st2_no_rsp_c4", 32'(rsp_valid), 32'd0);
        wready = 1;
        step();
        wready = 0;
        chk("st2_w_drop", 32'(wvalid), 32'd0);
        chk("st2_bready", 32'(bready), 32'd1);
        chk("st2_no_rsp_c5", 32'(rsp_valid), 32'd0);
        step();
        chk("st2_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("st2_rsp_err", 32'(rsp_err), 32'd0);
        step();
        chk("st2_single_rsp", 32'(rsp_valid), 32'd0);
        chk("st2_req_ready", 32'(req_ready), 32'd1);
        slave_idle();

        // Load OKAY
        arready = 1; rvalid = 1; rdata = 32'h1234_5678; rresp = 2'b00;
        issue(0, 32'h4000_0010, 32'd0, 4'h0);
        chk("ld1_arvalid", 32'(arvalid), 32'd1);
        chk("ld1_araddr", araddr, 32'h4000_0010);
        chk("ld1_awvalid", 32'(awvalid), 32'd0);
        step();
        chk("ld1_ar_drop", 32'(arvalid), 32'd0);
        chk("ld1_rready", 32'(rready), 32'd1);
        step();
        chk("ld1_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("ld1_rsp_rdata", rsp_rdata, 32'h1234_5678);
        chk("ld1_rsp_err", 32'(rsp_err), 32'd0);
        step();

        // Load SLVERR returns zero data
        rresp = 2'b10;
        issue(0, 32'h4000_0012, 32'd0, 4'h0);
        chk("ld2_araddr", araddr, 32'h4000_0010);
        step(); step();
        chk("ld2_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("ld2_rsp_rdata", rsp_rdata, 32'd0);
        chk("ld2_rsp_err", 32'(rsp_err), 32'd1);
        step();
        slave_idle();

        // Timeout: ARREADY never comes
        issue(0, 32'h4000_0100, 32'd0, 4'h0);
        cnt = 0;
        for (int i = 0; i < 20 && arvalid; i++) begin
            cnt++;
            step();
        end
        chk("to_arvalid_cycles", 32'(cnt), 32'd8);
        chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("to_rsp_err", 32'(rsp_err), 32'd1);
        chk("to_rsp_rdata", rsp_rdata, 32'd0);
        chk("to_rready", 32'(rready), 32'd0);
        step();
        chk("to_req_ready", 32'(req_ready), 32'd1);
        chk("to_rsp_drop", 32'(rsp_valid), 32'd0);

        // Reset while waiting in RD_DATA
        arready = 1;
        issue(0, 32'h4000_0200, 32'd0, 4'h0);
        step();
        chk("rr_rready", 32'(rready), 32'd1);
        rst = 1;
        step();
        rst = 0;
        chk("rr_rready_drop", 32'(rready), 32'd0);
        chk("rr_no_rsp", 32'(rsp_valid), 32'd0);
        chk("rr_req_ready", 32'(req_ready), 32'd1);
        chk("rr_addr_clear", araddr, 32'd0);
        step();
        chk("rr_no_rsp_after", 32'(rsp_valid), 32'd0);
        rvalid = 1; rdata = 32'hCAFE_F00D; rresp = 2'b00;
        issue(0, 32'h4000_0204, 32'd0, 4'h0);
        step(); step();
        chk("rr_new_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rr_new_rdata", rsp_rdata, 32'hCAFE_F00D);
        step();

        // req_valid held high across two back-to-back loads
        rdata = 32'h0BAD_F00D;
        req_valid = 1; req_we = 0; req_addr = 32'h4000_0300;
        accepts = 0; pulses = 0; second_idx = -1;
        for (int i = 0; i < 12; i++) begin
            if (rsp_valid) pulses++;
            if (req_valid && req_ready) begin
                accepts++;
                if (accepts == 2) second_idx = i;
            end
            step();
            if (accepts == 2) req_valid = 0;
        end
        chk("b2b_accepts", 32'(accepts), 32'd2);
        chk("b2b_second_idx", 32'(second_idx), 32'd4);
        chk("b2b_pulses", 32'(pulses), 32'd2);
        chk("b2b_last_rdata", rsp_rdata, 32'h0BAD_F00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
